cells_next_state_multi: RTL

Next-generation cell-update engine for the falling-sand pipeline. It scans the current frame in VRAM one cell at a time and builds the next frame in the scratch RAM. It supports multiple materials: sand falls down or diagonally, water also spreads sideways, and walls are static. Screen edges are handled explicitly, and a per-frame count of moved cells is reported.

---
 rtl/cells_next_state_multi_if.sv | 31 +++
 rtl/cells_next_state_multi.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cells_next_state_multi_if.sv
`timescale 1ns/1ps
// cells_next_state_multi_if: start/status and VRAM/scratch-RAM port bundle for the cell-update engine
interface cells_next_state_multi_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 2
);
    logic                  start_i;
    logic [DATA_WIDTH-1:0] vram_rd_data_i;
    logic [DATA_WIDTH-1:0] ram_rd_data_i;
    logic [ADDR_WIDTH-1:0] vram_rd_address_o;
    logic [ADDR_WIDTH-1:0] ram_rd_address_o;
    logic [ADDR_WIDTH-1:0] vram_wr_address_o;
    logic [ADDR_WIDTH-1:0] ram_wr_address_o;
    logic [DATA_WIDTH-1:0] vram_wr_data_o;
    logic [DATA_WIDTH-1:0] ram_wr_data_o;
    logic                  vram_wr_en_o;
    logic                  ram_wr_en_o;
    logic                  busy_o;
    logic                  done_o;
    logic [ADDR_WIDTH:0]   moved_count_o;
    modport master (
        input  start_i, vram_rd_data_i, ram_rd_data_i,
        output vram_rd_address_o, ram_rd_address_o, vram_wr_address_o, ram_wr_address_o,
        output vram_wr_data_o, ram_wr_data_o, vram_wr_en_o, ram_wr_en_o, busy_o, done_o, moved_count_o
    );
    modport slave (
        output start_i, vram_rd_data_i, ram_rd_data_i,
        input  vram_rd_address_o, ram_rd_address_o, vram_wr_address_o, ram_wr_address_o,
        input  vram_wr_data_o, ram_wr_data_o, vram_wr_en_o, ram_wr_en_o, busy_o, done_o, moved_count_o
    );
endinterface

// File: rtl/cells_next_state_multi.sv
`timescale 1ns/1ps
// cells_next_state_multi: falling-sand next-frame engine (VRAM -> scratch RAM); define CELLS_WATER_FLOW_EN for lateral water flow
module cells_next_state_multi #(
    parameter int         ACTIVE_COLUMNS = 640,
    parameter int         ACTIVE_ROWS    = 480,
    parameter int         ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int         DATA_WIDTH     = 2,
    parameter logic [7:0] LFSR_SEED      = 8'h01
) (
    input logic clk_i,
    input logic reset_i,
    cells_next_state_multi_if.master bus
);
    localparam int BW = ADDR_WIDTH + 1;
    localparam int CW = $clog2(ACTIVE_COLUMNS);
    localparam logic [BW-1:0] NB   = BW'(ACTIVE_COLUMNS * ACTIVE_ROWS);
    localparam logic [BW-1:0] COLS = BW'(ACTIVE_COLUMNS);
    localparam logic [CW-1:0] LAST = CW'(ACTIVE_COLUMNS - 1);
    typedef enum logic [2:0] {
        IDLE, SCAN, RD_D, RD_DL, RD_DR,
`ifdef CELLS_WATER_FLOW_EN
        RD_L, RD_R,
`endif
        GAP
    } state_t;
    state_t state, state_n;
    logic [BW-1:0] base, nxt, d_a, dl_a, dr_a, tgt, moved;
    logic [CW-1:0] col;
    logic [DATA_WIDTH-1:0] code, ram_wd;
    logic [7:0] lfsr;
    logic [ADDR_WIDTH-1:0] rd_a, ram_wa;
    logic occ_d, occ_dl, bottom, left, right, rd_occ, dl_f, dr_f, go_d, go_dl, go_dr;
    logic mv, stay, step, done, ram_we;
`ifdef CELLS_WATER_FLOW_EN
    logic [BW-1:0] l_a;
    logic occ_l, l_f, r_f, go_l, go_r;
`endif
    assign nxt    = base + 1'b1;
    assign d_a    = base + COLS;
    assign dl_a   = d_a - 1'b1;
    assign dr_a   = d_a + 1'b1;
    assign bottom = base >= NB - COLS;
    assign left   = col == '0;
    assign right  = col == LAST;
    assign rd_occ = |(bus.vram_rd_data_i | bus.ram_rd_data_i);
    assign dl_f   = !occ_dl;
    assign dr_f   = !(bottom || right || rd_occ);
    assign go_d   = !occ_d && (lfsr[1:0] != 2'd3 || !(dl_f || dr_f));
    assign go_dl  = !go_d && dl_f && (!dr_f || !lfsr[2]);
    assign go_dr  = !go_d && dr_f && (!dl_f || lfsr[2]);
`ifdef CELLS_WATER_FLOW_EN
    assign l_a  = base - 1'b1;
    assign l_f  = !occ_l;
    assign r_f  = !(right || rd_occ);
    assign go_l = l_f && (!r_f || !lfsr[2]);
    assign go_r = r_f && (!l_f || lfsr[2]);
`endif
    // state register; reset aborts any pass in progress
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else state <= state_n;
    end
    // next state, neighbour read address and move/stay/advance decision for the current cell
    always_comb begin
        state_n = state;
        rd_a    = '0;
        tgt     = d_a;
        mv      = 1'b0;
        stay    = 1'b0;
        step    = 1'b0;
        done    = 1'b0;
        ram_we  = 1'b0;
        ram_wa  = '0;
        ram_wd  = '0;
        case (state)
            IDLE: state_n = bus.start_i ? SCAN : IDLE;
            SCAN: begin
                if (base == NB) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else if (bus.vram_rd_data_i == '0) begin
                    step = 1'b1;
                end else if (bus.vram_rd_data_i == DATA_WIDTH'(1) || bus.vram_rd_data_i == DATA_WIDTH'(2)) begin
                    rd_a    = ADDR_WIDTH'(bottom ? base : d_a);
                    state_n = RD_D;
                end else begin
                    ram_we = 1'b1;
                    ram_wa = ADDR_WIDTH'(base);
                    ram_wd = bus.vram_rd_data_i;
                    step   = 1'b1;
                end
            end
            RD_D: begin
                rd_a    = ADDR_WIDTH'(bottom || left ? base : dl_a);
                state_n = RD_DL;
            end
            RD_DL: begin
                rd_a    = ADDR_WIDTH'(bottom || right ? base : dr_a);
                state_n = RD_DR;
            end
            RD_DR: begin
                mv  = go_d || go_dl || go_dr;
                tgt = go_d ? d_a : go_dl ? dl_a : dr_a;
`ifdef CELLS_WATER_FLOW_EN
                if (!mv && code == DATA_WIDTH'(2)) begin
                    rd_a    = ADDR_WIDTH'(left ? base : l_a);
                    state_n = RD_L;
                end else stay = !mv;
`else
                stay = !mv;
`endif
            end
`ifdef CELLS_WATER_FLOW_EN
            RD_L: begin
                rd_a    = ADDR_WIDTH'(right ? base : nxt);
                state_n = RD_R;
            end
            RD_R: begin
                mv   = go_l || go_r;
                tgt  = go_l ? l_a : nxt;
                stay = !mv;
            end
`endif
            GAP: step = 1'b1;
            default: state_n = IDLE;
        endcase
        if (mv) begin
            ram_we  = 1'b1;
            ram_wa  = ADDR_WIDTH'(tgt);
            ram_wd  = code;
            state_n = GAP;
        end
        if (stay) begin
            ram_we = 1'b1;
            ram_wa = ADDR_WIDTH'(base);
            ram_wd = code;
            step   = 1'b1;
        end
        if (step) begin
            rd_a    = nxt < NB ? ADDR_WIDTH'(nxt) : '0;
            state_n = SCAN;
        end
    end
    // scan position, latched cell code, sampled neighbour flags, move counter and free-running LFSR
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            base   <= '0;
            col    <= '0;
            moved  <= '0;
            code   <= '0;
            occ_d  <= 1'b0;
            occ_dl <= 1'b0;
            lfsr   <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (state == IDLE && bus.start_i) begin
                base  <= '0;
                col   <= '0;
                moved <= '0;
            end else if (step) begin
                base <= nxt;
                col  <= right ? '0 : col + 1'b1;
            end
            if (mv && moved != NB) moved <= moved + 1'b1;
            if (state == SCAN) code <= bus.vram_rd_data_i;
            if (state == RD_D) occ_d <= bottom || rd_occ;
            if (state == RD_DL) occ_dl <= bottom || left || rd_occ;
        end
    end
`ifdef CELLS_WATER_FLOW_EN
    // left-neighbour flag, held until the lateral decision
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) occ_l <= 1'b0;
        else if (state == RD_L) occ_l <= left || rd_occ;
    end
`endif
    assign bus.vram_rd_address_o = rd_a;
    assign bus.ram_rd_address_o  = rd_a;
    assign bus.vram_wr_en_o      = mv;
    assign bus.vram_wr_address_o = mv ? ADDR_WIDTH'(base) : '0;
    assign bus.vram_wr_data_o    = '0;
    assign bus.ram_wr_en_o       = ram_we;
    assign bus.ram_wr_address_o  = ram_wa;
    assign bus.ram_wr_data_o     = ram_wd;
    assign bus.busy_o            = state != IDLE;
    assign bus.done_o            = done;
    assign bus.moved_count_o     = moved;
endmodule
